// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR + R) between N requesters.
// One requester owns the channel from grant until its last R beat or until it withdraws.
module axi_read_arbiter #(
    parameter int N_MASTERS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_MASTERS-1:0]   m_req,
    output logic [N_MASTERS-1:0]   m_grnt,
    input  logic [N_MASTERS*4-1:0]  m_arid,
    input  logic [N_MASTERS*32-1:0] m_araddr,
    input  logic [N_MASTERS*4-1:0]  m_arlen,
    input  logic [N_MASTERS*3-1:0]  m_arsize,
    input  logic [N_MASTERS*2-1:0]  m_arburst,
    input  logic [N_MASTERS*2-1:0]  m_arlock,
    input  logic [N_MASTERS*4-1:0]  m_arcache,
    input  logic [N_MASTERS*3-1:0]  m_arprot,
    input  logic [N_MASTERS-1:0]   m_arvalid,
    output logic [N_MASTERS-1:0]   m_arready,
    output logic [3:0]             m_rid,
    output logic [31:0]            m_rdata,
    output logic [1:0]             m_rresp,
    output logic                   m_rlast,
    output logic [N_MASTERS-1:0]   m_rvalid,
    input  logic [N_MASTERS-1:0]   m_rready,
    output logic [3:0]             arid,
    output logic [31:0]            araddr,
    output logic [3:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic [1:0]             arlock,
    output logic [3:0]             arcache,
    output logic [2:0]             arprot,
    output logic                   arvalid,
    input  logic                   arready,
    input  logic [3:0]             rid,
    input  logic [31:0]            rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    input  logic                   rvalid,
    output logic                   rready,
    output logic                   AXI_Load_Bus_busy
);

    localparam int N     = N_MASTERS;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W:0]   N_EXT    = N[PTR_W:0];
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state_reg;
    logic [N-1:0]     grnt_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] gidx_reg;

    logic             in_addr;
    logic             in_data;
    logic             ar_hs;
    logic             r_last_hs;
    logic             req_held;
    logic [N-1:0]     req_rot;
    logic [PTR_W-1:0] pick_off;
    logic [PTR_W:0]   pick_sum;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W-1:0] ptr_next;

    assign in_addr = (state_reg == ADDR);
    assign in_data = (state_reg == DATA);

    // Rotate requests so bit 0 is the current highest-priority requester,
    // then take the lowest set bit and map it back to an absolute index.
    always_comb begin
        req_rot  = N'({m_req, m_req} >> ptr_reg);
        pick_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_off = PTR_W'(i);
            end
        end
        pick_sum = {1'b0, ptr_reg} + {1'b0, pick_off};
        pick_idx = (pick_sum >= N_EXT) ? PTR_W'(pick_sum - N_EXT) : pick_sum[PTR_W-1:0];
    end

    assign ptr_next = (gidx_reg == LAST_IDX) ? '0 : gidx_reg + PTR_W'(1);

    always_comb begin
        arid    = '0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        arlock  = '0;
        arcache = '0;
        arprot  = '0;
        arvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_addr && grnt_reg[i]) begin
                arid    = m_arid[i*4 +: 4];
                araddr  = m_araddr[i*32 +: 32];
                arlen   = m_arlen[i*4 +: 4];
                arsize  = m_arsize[i*3 +: 3];
                arburst = m_arburst[i*2 +: 2];
                arlock  = m_arlock[i*2 +: 2];
                arcache = m_arcache[i*4 +: 4];
                arprot  = m_arprot[i*3 +: 3];
                arvalid = m_arvalid[i];
            end
        end
    end

    assign ar_hs     = arvalid && arready;
    assign rready    = in_data && (|(grnt_reg & m_rready));
    assign r_last_hs = rvalid && rready && rlast;
    assign req_held  = |(m_req & grnt_reg);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_route
            assign m_arready[gi] = in_addr && grnt_reg[gi] && arready;
            assign m_rvalid[gi]  = in_data && grnt_reg[gi] && rvalid;
        end
    endgenerate

    // R payload is broadcast; only rvalid is steered by the grant.
    assign m_rid   = rid;
    assign m_rdata = rdata;
    assign m_rresp = rresp;
    assign m_rlast = rlast;

    assign m_grnt            = grnt_reg;
    assign AXI_Load_Bus_busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            grnt_reg  <= '0;
            ptr_reg   <= '0;
            gidx_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|m_req) begin
                        state_reg <= ADDR;
                        grnt_reg  <= N'(1) << pick_idx;
                        gidx_reg  <= pick_idx;
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        state_reg <= DATA;
                    end else if (!req_held) begin
                        // Requester withdrew before issuing its address.
                        state_reg <= IDLE;
                        grnt_reg  <= '0;
                        ptr_reg   <= ptr_next;
                    end
                end
                DATA: begin
                    if (r_last_hs) begin
                        state_reg <= IDLE;
                        grnt_reg  <= '0;
                        ptr_reg   <= ptr_next;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grnt_reg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the single AXI read channel (AR + R) of the memory-side bus between N read requesters: instruction cache refill, data cache refill and the uncached loader. Each requester raises `req`, waits for `grnt`, then drives a full AR handshake and consumes one complete R burst. The arbiter grants one requester at a time in round-robin order and muxes its AR signals onto the bus. It routes R beats back to the granted requester only, and exports `AXI_Load_Bus_busy` so requesters can hold off.

## Interface
- `N_MASTERS`, default 3: number of requesters. Index 0 = icache, 1 = dcache, 2 = uncached loader.
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high
- `m_req`  in  N  per-requester bus request, level, held until its last R beat
- `m_grnt`  out  N  one-hot grant, registered
- `m_arid`/`m_araddr`/`m_arlen`/`m_arsize`/`m_arburst`/`m_arlock`/`m_arcache`/`m_arprot`  in  N×(4/32/4/3/2/2/4/3)  packed per-requester AR fields; slice k belongs to requester k
- `m_arvalid`  in  N  per-requester AR valid
- `m_arready`  out  N  AR ready, routed to granted requester only
- `m_rid`/`m_rdata`/`m_rresp`/`m_rlast`  out  4/32/2/1  R payload broadcast to all requesters
- `m_rvalid`  out  N  R valid, routed to granted requester only
- `m_rready`  in  N  per-requester R ready
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arlock`/`arcache`/`arprot`/`arvalid`  out  4/32/4/3/2/2/4/3/1  bus AR channel
- `arready`  in  1  bus AR ready
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid`  in  4/32/2/1/1  bus R channel
- `rready`  out  1  bus R ready
- `AXI_Load_Bus_busy`  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, ADDR, DATA.
- Registers: `state`, `grnt` (one-hot), `ptr` (index of highest-priority requester, log2(N) bits).
- **IDLE:**
  - If any `m_req`, select the first asserted requester scanning ptr, ptr+1, …, wrapping modulo N.
  - Set `grnt` one-hot to that requester and go to ADDR.
  - With no requests, stay in IDLE with `grnt`=0.
- **ADDR:**
  - `arvalid` and all AR fields = granted slice. `m_arready[g]` = `arready`; other `m_arready` bits = 0.
  - On `arvalid && arready`, go to DATA.
  - If `m_req[g]` drops before the AR handshake (requester withdrew), release the grant.
- **DATA:**
  - `m_rvalid[g]` = `rvalid`; `rready` = `m_rready[g]`. Other `m_rvalid` bits = 0.
  - Routing is by grant, not by `rid`; `rid` is passed through unchanged.
  - On `rvalid && rready && rlast`, release the grant.
- **Release:**
  - Next cycle `grnt`=0 and state = IDLE.
  - `ptr` = (g+1) mod N, where g is the requester just served, so the last-served requester gets lowest priority.
- Outside ADDR: `arvalid`=0 and AR fields = 0. Outside DATA: `rready`=0 and all `m_rvalid`=0.
- An R beat arriving in IDLE or ADDR is not forwarded and not accepted (`rready`=0).
- Requester-side `busy` = `AXI_Load_Bus_busy && (!req || !grnt)` is correct by construction: the granted requester sees itself as not blocked.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, `grnt`=0, `ptr`=0.
  - `arvalid`=0, `rready`=0, all `m_arready`/`m_rvalid`=0, `AXI_Load_Bus_busy`=0, AR fields=0.
- Reset mid-burst drops the grant immediately. Outstanding bus beats are not the arbiter's concern after reset.
- Grant latency: `req` sampled high in IDLE at edge t gives `grnt` high after edge t; earliest AR handshake is in the cycle after t.
- AR/R paths are combinational through the mux. No added latency; bus handshakes complete in the same cycle the requester sees them.
- Release occupies one cycle. After the last beat, `grnt` is 0 for at least one full cycle (IDLE) before any regrant. Back-to-back bursts are therefore separated by ≥1 idle cycle.
- `AXI_Load_Bus_busy` is asserted from the cycle after grant through the cycle of the last-beat handshake. It deasserts with the return to IDLE.
- If a new `req` arrives in the same cycle as release, it is arbitrated in the following IDLE cycle using the updated `ptr`.
- `grnt` never changes while state = DATA.

## Test plan
- **Single uncached read:** `m_req`=3'b100, `araddr`=0x1FD0_F000, `arlen`=0, `arready` after 2 cycles, one R beat `rdata`=0xDEAD_BEEF with `rlast` → `grnt`=3'b100 one cycle after req. `m_rvalid[2]` pulses with that data; `grnt`=0 and `busy`=0 the cycle after.
- **Simultaneous requests:** all three `req` high from reset, each doing a 1-beat read → grant order 0, 1, 2, with exactly one IDLE cycle between grants. Then `ptr`=0.
- **Burst with stalls:** dcache `arlen`=7; `m_rready` toggles 1,0,1,0… → exactly 8 beats forwarded and bus `rready` mirrors `m_rready[1]`. Release occurs only on the beat with `rlast`.
- **Isolation:** stray `rvalid` while IDLE, and R beats while icache is granted → `rready`=0 in IDLE. `m_rvalid[1]`/`m_rvalid[2]` stay 0 throughout.
- **Withdraw:** grant icache, drop `m_req[0]` before `arvalid` → back to IDLE next cycle, `ptr`=1, dcache request then granted.
- **Reset mid-burst:** assert `rst` during beat 3 of an 8-beat burst → same-cycle `grnt`=0, `busy`=0, `rready`=0. After release, a new request is granted normally with `ptr`=0.
